// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue stage and the add/sub coprocessor it feeds.
package fpu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREG       = 32;

    typedef enum logic [2:0] {
        FpuOpAdd = 3'b000,
        FpuOpSub = 3'b001
    } fpu_op_e;

endpackage

// File: rtl/fpu_issue_stage_if.sv
// Issue, external-write, coprocessor, writeback and debug signals of the FP issue stage.
interface fpu_issue_stage_if;
    import fpu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_op;
    logic [REG_ADDR_W-1:0] in_fs;
    logic [REG_ADDR_W-1:0] in_ft;
    logic [REG_ADDR_W-1:0] in_fd;

    logic                  ext_wr_en;
    logic [REG_ADDR_W-1:0] ext_wr_addr;
    logic [DATA_W-1:0]     ext_wr_data;

    logic [DATA_W-1:0]     cop_data1;
    logic [DATA_W-1:0]     cop_data2;
    logic [2:0]            cop_op;
    logic [DATA_W-1:0]     cop_res;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;

    logic [REG_ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_data;

    // Stage side.
    modport slave (
        input  in_valid, in_op, in_fs, in_ft, in_fd,
        input  ext_wr_en, ext_wr_addr, ext_wr_data,
        input  cop_res, dbg_addr,
        output in_ready, cop_data1, cop_data2, cop_op,
        output wb_valid, wb_addr, wb_data, dbg_data
    );

    // Instruction source / environment side.
    modport master (
        output in_valid, in_op, in_fs, in_ft, in_fd,
        output ext_wr_en, ext_wr_addr, ext_wr_data,
        output cop_res, dbg_addr,
        input  in_ready, cop_data1, cop_data2, cop_op,
        input  wb_valid, wb_addr, wb_data, dbg_data
    );

endinterface

// File: rtl/fp_regfile.sv
// 32x32 FP register file: two async operand reads, one debug read, external and commit
// write ports where the commit wins on an address match.
module fp_regfile
    import fpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ext_en,
    input  logic [REG_ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0]     ext_data,
    input  logic                  cmt_en,
    input  logic [REG_ADDR_W-1:0] cmt_addr,
    input  logic [DATA_W-1:0]     cmt_data,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0]     rd_data1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0]     rd_data2,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (ext_en) begin
                mem[ext_addr] <= ext_data;
            end
            // Later assignment takes effect, so the commit overrides the external write.
            if (cmt_en) begin
                mem[cmt_addr] <= cmt_data;
            end
        end
    end

    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/fpu_issue_stage.sv
// FP issue/writeback stage in front of the add/sub coprocessor.
// Define FPU_ISSUE_FORWARD_EN to bypass cop_res into operand select and drop the hazard stall.
module fpu_issue_stage
    import fpu_pkg::*;
(
    input logic              clk,
    input logic              reset_n,
    fpu_issue_stage_if.slave bus
);

    logic                  e_valid_q;
    logic [REG_ADDR_W-1:0] e_fd_q;
    logic [DATA_W-1:0]     cop_data1_q;
    logic [DATA_W-1:0]     cop_data2_q;
    logic [2:0]            cop_op_q;
    logic                  wb_valid_q;
    logic [REG_ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0]     wb_data_q;

    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              stall;
    logic              accept;

    fp_regfile u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .ext_en   (bus.ext_wr_en),
        .ext_addr (bus.ext_wr_addr),
        .ext_data (bus.ext_wr_data),
        .cmt_en   (e_valid_q),
        .cmt_addr (e_fd_q),
        .cmt_data (bus.cop_res),
        .rd_addr1 (bus.in_fs),
        .rd_data1 (rf_data1),
        .rd_addr2 (bus.in_ft),
        .rd_data2 (rf_data2),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data)
    );

    // Lowest priority first; each later match overrides.
    always_comb begin
        op_a = rf_data1;
        op_b = rf_data2;
        if (bus.ext_wr_en && bus.ext_wr_addr == bus.in_fs) begin
            op_a = bus.ext_wr_data;
        end
        if (bus.ext_wr_en && bus.ext_wr_addr == bus.in_ft) begin
            op_b = bus.ext_wr_data;
        end
`ifdef FPU_ISSUE_FORWARD_EN
        if (e_valid_q && e_fd_q == bus.in_fs) begin
            op_a = bus.cop_res;
        end
        if (e_valid_q && e_fd_q == bus.in_ft) begin
            op_b = bus.cop_res;
        end
`endif
    end

`ifdef FPU_ISSUE_FORWARD_EN
    assign stall = 1'b0;
`else
    // The in-flight result lands in the register file at the next edge, so wait one cycle.
    assign stall = e_valid_q && (e_fd_q == bus.in_fs || e_fd_q == bus.in_ft);
`endif

    assign bus.in_ready = reset_n && !stall;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_valid_q   <= 1'b0;
            e_fd_q      <= '0;
            cop_data1_q <= '0;
            cop_data2_q <= '0;
            cop_op_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            e_valid_q  <= accept;
            wb_valid_q <= e_valid_q;
            if (accept) begin
                e_fd_q      <= bus.in_fd;
                cop_data1_q <= op_a;
                cop_data2_q <= op_b;
                cop_op_q    <= bus.in_op;
            end
            if (e_valid_q) begin
                wb_addr_q <= e_fd_q;
                wb_data_q <= bus.cop_res;
            end
        end
    end

    assign bus.cop_data1 = cop_data1_q;
    assign bus.cop_data2 = cop_data2_q;
    assign bus.cop_op    = cop_op_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_addr   = wb_addr_q;
    assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Bench for fpu_issue_stage: directed scenarios plus random traffic against an architectural model.
module tb_fpu_issue_stage;
    import fpu_pkg::*;

`ifdef FPU_ISSUE_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fpu_issue_stage_if bus ();

    fpu_issue_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Coprocessor stand-in: single-precision add/sub via double, truncating, denormals flushed.
    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] to_bits(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] cop_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        real ra, rb;
        ra = to_real(a);
        rb = to_real(b);
        return to_bits((op == FpuOpSub) ? ra - rb : ra + rb);
    endfunction

    always_comb bus.cop_res = cop_fn(bus.cop_data1, bus.cop_data2, bus.cop_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: an instruction accepted at an edge sees the registers as they stand
    // after that edge (external write, then overriding commit); its result commits one edge later.
    logic [31:0] m_reg [32];
    bit          m_live = 1'b0;
    bit          m_rst  = 1'b0;
    bit          p_v    = 1'b0;
    logic [4:0]  p_fd;
    logic [31:0] p_res;
    logic [31:0] exp_cop1, exp_cop2;
    logic [2:0]  exp_op;
    bit          exp_wbv;
    logic [4:0]  exp_wba;
    logic [31:0] exp_wbd;

    function automatic bit model_ready();
        return reset_n && !(!Fwd && p_v && (p_fd == bus.in_fs || p_fd == bus.in_ft));
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] nr [32];
        bit          acc;
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_reg[i] <= '0;
            p_v      <= 1'b0;
            exp_cop1 <= '0;
            exp_cop2 <= '0;
            exp_op   <= '0;
            exp_wbv  <= 1'b0;
            exp_wba  <= '0;
            exp_wbd  <= '0;
            m_live   <= 1'b1;
            m_rst    <= 1'b1;
        end else begin
            acc = bus.in_valid && model_ready();
            nr  = m_reg;
            if (bus.ext_wr_en) nr[bus.ext_wr_addr] = bus.ext_wr_data;
            if (p_v) begin
                nr[p_fd] = p_res;
                exp_wba <= p_fd;
                exp_wbd <= p_res;
            end
            exp_wbv <= p_v;
            m_rst   <= 1'b0;
            p_v     <= acc;
            if (acc) begin
                exp_cop1 <= nr[bus.in_fs];
                exp_cop2 <= nr[bus.in_ft];
                exp_op   <= bus.in_op;
                p_fd     <= bus.in_fd;
                p_res    <= cop_fn(nr[bus.in_fs], nr[bus.in_ft], bus.in_op);
            end
            m_reg <= nr;
        end
    end

    always @(negedge clk) begin : compare
        if (m_live) begin
            chk("in_ready", 32'(bus.in_ready), 32'(model_ready()));
            chk("wb_valid", 32'(bus.wb_valid), 32'(exp_wbv));
            if (exp_wbv || m_rst) begin
                chk("wb_addr", 32'(bus.wb_addr), 32'(exp_wba));
                chk("wb_data", bus.wb_data, exp_wbd);
            end
            chk("cop_data1", bus.cop_data1, exp_cop1);
            chk("cop_data2", bus.cop_data2, exp_cop2);
            chk("cop_op", 32'(bus.cop_op), 32'(exp_op));
            chk("dbg_data", bus.dbg_data, m_reg[bus.dbg_addr]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] op, input int fd, input int fs, input int ft);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_fd    = 5'(fd);
        bus.in_fs    = 5'(fs);
        bus.in_ft    = 5'(ft);
    endtask

    task automatic ext(input bit en, input int addr, input logic [31:0] data);
        bus.ext_wr_en   = en;
        bus.ext_wr_addr = 5'(addr);
        bus.ext_wr_data = data;
    endtask

    task automatic dbg(input string name, input int addr, input logic [31:0] exp);
        bus.dbg_addr = 5'(addr);
        #1;
        chk(name, bus.dbg_data, exp);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_fd    = '0;
        bus.in_fs    = '0;
        bus.in_ft    = '0;
        bus.dbg_addr = '0;
        ext(1'b0, 0, '0);

        // Reset
        cyc();
        cyc();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_cop_data1", bus.cop_data1, 32'd0);
        chk("rst_cop_op", 32'(bus.cop_op), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 32; i++) dbg("rst_dbg", i, 32'd0);

        // Basic add
        @(posedge clk);
        #2;
        ext(1'b1, 1, 32'h3F800000);
        cyc();
        ext(1'b1, 2, 32'h40000000);
        cyc();
        ext(1'b0, 0, '0);
        issue(FpuOpAdd, 3, 1, 2);
        cyc();
        bus.in_valid = 1'b0;
        chk("add_cop1", bus.cop_data1, 32'h3F800000);
        chk("add_cop2", bus.cop_data2, 32'h40000000);
        chk("add_op", 32'(bus.cop_op), 32'(FpuOpAdd));
        cyc();
        chk("add_wbv", 32'(bus.wb_valid), 32'd1);
        chk("add_wba", 32'(bus.wb_addr), 32'd3);
        chk("add_wbd", bus.wb_data, 32'h40400000);
        dbg("add_f3", 3, 32'h40400000);
        cyc();
        chk("add_wbv_pulse", 32'(bus.wb_valid), 32'd0);

        // Dependent back-to-back; f3 cleared first so a stale read would show
        ext(1'b1, 3, 32'h0);
        cyc();
        ext(1'b0, 0, '0);
        issue(FpuOpAdd, 3, 1, 2);
        cyc();
        issue(FpuOpAdd, 4, 3, 1);
        #1;
        chk("dep_ready", 32'(bus.in_ready), 32'(Fwd));
        if (!Fwd) begin
            cyc();
            chk("dep_ready_after", 32'(bus.in_ready), 32'd1);
        end
        cyc();
        bus.in_valid = 1'b0;
        chk("dep_cop1", bus.cop_data1, 32'h40400000);
        chk("dep_cop2", bus.cop_data2, 32'h3F800000);
        cyc();
        chk("dep_wba", 32'(bus.wb_addr), 32'd4);
        chk("dep_wbd", bus.wb_data, 32'h40800000);
        dbg("dep_f4", 4, 32'h40800000);

        // Write collision: commit beats ext on same address, different address both land
        issue(FpuOpAdd, 3, 1, 1);
        cyc();
        bus.in_valid = 1'b0;
        ext(1'b1, 3, 32'hDEADBEEF);
        cyc();
        ext(1'b0, 0, '0);
        dbg("col_f3", 3, 32'h40000000);
        issue(FpuOpAdd, 3, 1, 2);
        cyc();
        bus.in_valid = 1'b0;
        ext(1'b1, 5, 32'hDEADBEEF);
        cyc();
        ext(1'b0, 0, '0);
        dbg("col_f5", 5, 32'hDEADBEEF);
        dbg("col_f3b", 3, 32'h40400000);

        // Ext bypass into operand select
        ext(1'b1, 6, 32'h3F800000);
        issue(FpuOpSub, 8, 6, 1);
        cyc();
        ext(1'b0, 0, '0);
        bus.in_valid = 1'b0;
        chk("byp_cop1", bus.cop_data1, 32'h3F800000);
        cyc();
        chk("byp_wbd", bus.wb_data, 32'h0);

        // Reset mid-op
        cyc();
        issue(FpuOpAdd, 7, 1, 2);
        cyc();
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        cyc();
        chk("midrst_wbv0", 32'(bus.wb_valid), 32'd0);
        cyc();
        chk("midrst_wbv1", 32'(bus.wb_valid), 32'd0);
        reset_n = 1'b1;
        dbg("midrst_f7", 7, 32'h0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            cyc();
            reset_n      = ($urandom_range(0, 299) != 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_op    = 3'($urandom_range(0, 1));
            bus.in_fd    = 5'($urandom_range(0, (c % 5 == 0) ? 31 : 7));
            bus.in_fs    = 5'($urandom_range(0, 7));
            bus.in_ft    = 5'($urandom_range(0, 7));
            bus.dbg_addr = 5'($urandom_range(0, 31));
            ext(($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)});
        end
        cyc();
        bus.in_valid = 1'b0;
        ext(1'b0, 0, '0);
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
